button_array_ctrl: RTL and testbench
====================================

Name: button_array_ctrl

Overview:
N-channel front-panel button controller, next generation of the power/reset button logic, running on the 32,768 Hz SlowClock domain.
- Each channel debounces an active-low button input and classifies it as released/pressed/held/long-press.
- Per-channel mode: debounced level output, or a one-window reset strobe after a long press.
- Adds sticky, acknowledgeable interrupt status and an external per-channel inhibit.

Parameters:
N_BTN, 2, number of button channels
DEB_DEPTH, 3, debounce shift-register depth in Strobe16ms samples (2..8)
TMR_W, 6, hold-timer width in 125 ms ticks
INT_TICKS, 7, timer value at which PressIrq fires (1 s)
LONG_TICKS, 31, timer value that defines long press / strobe window (~4 s)
RST_MASK, 2'b10, bit i=1: channel i is strobe mode; 0: level mode

Ports:
SlowClock  in  1  32,768 Hz clock
MainReset  in  1  reset
Strobe16ms  in  1  single-cycle tick every 16 ms
Strobe125ms  in  1  single-cycle tick every 125 ms
ButtonIn  in  N_BTN  raw buttons, active-low (0 = pushed)
Inhibit  in  N_BTN  forces ButtonOut[i] inactive (e.g. watchdog reset in progress)
IrqAck  in  N_BTN  single-cycle clear of IrqPending[i]
ButtonOut  out  N_BTN  level mode: debounced status (1 = released); strobe mode: active-low reset strobe
PressIrq  out  N_BTN  1-cycle pulse, hold reached INT_TICKS
ReleaseIrq  out  N_BTN  1-cycle pulse on debounced release
LongPress  out  N_BTN  level, timer >= LONG_TICKS
IrqPending  out  N_BTN  sticky OR of PressIrq/ReleaseIrq

Behaviour:
- Reset: MainReset asynchronous, active-low; clock SlowClock.
- Reset values: debounce regs all-ones; Status = 1 (released); timer 0; ButtonOut all 1; PressIrq, ReleaseIrq, LongPress, IrqPending all 0.
- Debounce: on Strobe16ms, shift ButtonIn into the DEB_DEPTH register.
  - Status sets when the register is all-ones, clears when all-zeros, otherwise holds.
  - This takes DEB_DEPTH consecutive samples to change, same-cycle update.
- Channel FSM, derived from Status and timer:
  - IDLE: Status = 1.
  - PRESS: Status = 0, timer < INT_TICKS.
  - HELD: INT_TICKS <= timer < LONG_TICKS.
  - LONG: timer >= LONG_TICKS.
  - Any state returns to IDLE on the Strobe16ms where Status sets.
- Timer: on Strobe125ms, cleared while Status = 1; otherwise increments, saturating at 2^TMR_W - 1 (no wrap).
- PressIrq[i]: registered; equals (timer == INT_TICKS) & Strobe125ms. Fires once per press.
- ReleaseIrq[i]: registered; equals (debounce all-ones) & !Status & Strobe16ms. Coincides with the IDLE transition.
- LongPress[i]: registered; equals timer >= LONG_TICKS.
- Strobe mode: ButtonOut[i] = registered (timer != LONG_TICKS).
  - Low for exactly one 125 ms window (4096 cycles), 1 cycle after the timer reaches LONG_TICKS.
- Level mode: ButtonOut[i] = Status.
- Inhibit[i] = 1 forces ButtonOut[i] = 1 combinationally. Timer, IRQs and LongPress are unaffected.
- IrqPending[i]: set by PressIrq or ReleaseIrq; cleared by IrqAck. Set and ack in the same cycle: set wins.
- Strobe16ms and Strobe125ms in the same cycle: both updates apply; the timer uses the pre-update Status.
- Release in the same 125 ms tick as an increment: the timer clears on the next Strobe125ms.
- Reset mid-press: all state returns to reset values immediately. After reset, DEB_DEPTH low samples are needed before Status clears.
- Parameter constraints (elaboration error otherwise): INT_TICKS < LONG_TICKS < 2^TMR_W.

Optional Feature:
BTN_STUCK_DETECT_EN
- Defined:
  - Adds per-channel output Stuck[i], reset 0.
  - Stuck sets when the timer saturates (2^TMR_W - 1) and clears on debounced release.
  - While Stuck, ButtonOut[i] is forced 1 and PressIrq/ReleaseIrq for that channel are suppressed, including the release that clears Stuck.
- Undefined: no Stuck port; a saturated timer simply holds.

Decomposition:
- Package button_pkg:
  - channel state enum (IDLE/PRESS/HELD/LONG)
  - default tick constants: INT_1S = 7, LONG_4S = 31
  - debounce all-ones/all-zeros helper constants
- Sub-module button_channel: one channel (debounce, Status, timer, FSM, per-channel outputs).
  - Instantiated N_BTN times via generate.
  - Top level holds only IrqPending, IrqAck and Inhibit muxing.

Test Plan:
1. Reset, then ButtonIn = all 1 for 1 s -> ButtonOut = 2'b11, no IRQs, IrqPending = 0.
2. Channel 0 (level) held low 2 s -> ButtonOut[0] falls after the 3rd low Strobe16ms; PressIrq[0] pulses once on the 8th Strobe125ms after Status clears; IrqPending[0] = 1 until IrqAck.
3. Channel 1 (strobe) held low 5 s -> ButtonOut[1] low for exactly 4096 cycles starting ~4 s; LongPress[1] = 1 from then until release; single ReleaseIrq[1] after 3 high samples.
4. Glitch channel 0 low for 2 Strobe16ms samples, then high -> no Status change, no IRQ.
5. IrqAck[0] in the same cycle as ReleaseIrq[0] -> IrqPending[0] stays 1. Inhibit[1] = 1 during a long press -> ButtonOut[1] stays 1 while LongPress[1] still asserts.
6. MainReset pulsed low mid-hold (timer = 20) -> all outputs return to reset values; after release, re-press reproduces scenario 3 timing from zero.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and constants for the front-panel button controller.
package button_pkg;

  // Channel classification. Status=1 is always IDLE; otherwise the hold timer picks the state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HELD  = 2'd2,
    ST_LONG  = 2'd3
  } btn_state_e;

  // Default hold thresholds in 125 ms ticks.
  localparam int INT_1S  = 7;
  localparam int LONG_4S = 31;

  // Debounce compare patterns, sliced to DEB_DEPTH (max 8) by the user.
  localparam logic [7:0] DEB_ONES  = 8'hFF;
  localparam logic [7:0] DEB_ZEROS = 8'h00;

endpackage

// File: rtl/button_channel.sv
// One button channel: debounce, Status, hold timer, state, per-channel outputs.
// Optional stuck-button detection is built when BTN_STUCK_DETECT_EN is defined.
module button_channel
  import button_pkg::*;
#(
  parameter int DEB_DEPTH   = 3,
  parameter int TMR_W       = 6,
  parameter int INT_TICKS   = INT_1S,
  parameter int LONG_TICKS  = LONG_4S,
  parameter bit STROBE_MODE = 1'b0
) (
  input  logic SlowClock,
  input  logic MainReset,
  input  logic strobe16_i,
  input  logic strobe125_i,
  input  logic btn_n_i,
  output logic btn_out_o,
  output logic press_irq_o,
  output logic release_irq_o,
  output logic long_press_o
`ifdef BTN_STUCK_DETECT_EN
  ,
  output logic stuck_o
`endif
);

  localparam logic [TMR_W-1:0] TMR_MAX = '1;
  localparam logic [TMR_W-1:0] INT_T   = TMR_W'(INT_TICKS);
  localparam logic [TMR_W-1:0] LONG_T  = TMR_W'(LONG_TICKS);

  logic [DEB_DEPTH-1:0] deb_q, deb_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  btn_state_e           state_q, state_d;
  logic                 status, status_d;
  logic                 release_evt, suppress;
  logic                 press_q, release_q, long_q, strobe_q;

  // Status (1 = released) is exactly "state is IDLE", so the FSM register holds it.
  assign status = (state_q == ST_IDLE);

  // Next-state: debounce shift, Status hysteresis, saturating timer on pre-update Status.
  always_comb begin
    deb_d       = deb_q;
    status_d    = status;
    timer_d     = timer_q;
    release_evt = 1'b0;
    if (strobe16_i) begin
      deb_d = {deb_q[DEB_DEPTH-2:0], btn_n_i};
      if (deb_d == DEB_ONES[DEB_DEPTH-1:0]) begin
        status_d    = 1'b1;
        release_evt = !status;
      end else if (deb_d == DEB_ZEROS[DEB_DEPTH-1:0]) begin
        status_d = 1'b0;
      end
    end
    if (strobe125_i) begin
      if (status)                  timer_d = '0;
      else if (timer_q != TMR_MAX) timer_d = timer_q + 1'b1;
    end
    if (status_d)               state_d = ST_IDLE;
    else if (timer_d >= LONG_T) state_d = ST_LONG;
    else if (timer_d >= INT_T)  state_d = ST_HELD;
    else                        state_d = ST_PRESS;
  end

  // Channel FSM and registered outputs; IRQ/strobe terms use the pre-edge timer.
  always_ff @(posedge SlowClock or negedge MainReset) begin
    if (!MainReset) begin
      deb_q     <= '1;
      timer_q   <= '0;
      state_q   <= ST_IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      strobe_q  <= 1'b1;
    end else begin
      deb_q     <= deb_d;
      timer_q   <= timer_d;
      state_q   <= state_d;
      press_q   <= strobe125_i && (timer_q == INT_T) && !suppress;
      release_q <= release_evt && !suppress;
      long_q    <= (timer_q >= LONG_T);
      strobe_q  <= (timer_q != LONG_T);
    end
  end

`ifdef BTN_STUCK_DETECT_EN
  logic stuck_q;

  // Stuck latches when the timer saturates and holds until the debounced release.
  always_ff @(posedge SlowClock or negedge MainReset) begin
    if (!MainReset)                            stuck_q <= 1'b0;
    else if (release_evt)                      stuck_q <= 1'b0;
    else if (!status_d && timer_d == TMR_MAX)  stuck_q <= 1'b1;
  end

  assign suppress = stuck_q;
  assign stuck_o  = stuck_q;
`else
  assign suppress = 1'b0;
`endif

  assign btn_out_o     = suppress | (STROBE_MODE ? strobe_q : status);
  assign press_irq_o   = press_q;
  assign release_irq_o = release_q;
  assign long_press_o  = long_q;

endmodule

// File: rtl/button_array_ctrl.sv
// N-channel front-panel button controller on SlowClock (32,768 Hz).
// Top keeps only IrqPending and the Inhibit override; channels do the rest.
// Define BTN_STUCK_DETECT_EN to add the per-channel Stuck output.
module button_array_ctrl
  import button_pkg::*;
#(
  parameter int               N_BTN      = 2,
  parameter int               DEB_DEPTH  = 3,
  parameter int               TMR_W      = 6,
  parameter int               INT_TICKS  = INT_1S,
  parameter int               LONG_TICKS = LONG_4S,
  parameter logic [N_BTN-1:0] RST_MASK   = N_BTN'(2'b10)
) (
  input  logic             SlowClock,
  input  logic             MainReset,
  input  logic             Strobe16ms,
  input  logic             Strobe125ms,
  input  logic [N_BTN-1:0] ButtonIn,
  input  logic [N_BTN-1:0] Inhibit,
  input  logic [N_BTN-1:0] IrqAck,
  output logic [N_BTN-1:0] ButtonOut,
  output logic [N_BTN-1:0] PressIrq,
  output logic [N_BTN-1:0] ReleaseIrq,
  output logic [N_BTN-1:0] LongPress,
  output logic [N_BTN-1:0] IrqPending
`ifdef BTN_STUCK_DETECT_EN
  ,
  output logic [N_BTN-1:0] Stuck
`endif
);

  if (!(INT_TICKS < LONG_TICKS && LONG_TICKS < (1 << TMR_W))) begin : g_bad_ticks
    $error("button_array_ctrl: need INT_TICKS < LONG_TICKS < 2**TMR_W");
  end
  if (DEB_DEPTH < 2 || DEB_DEPTH > 8) begin : g_bad_deb
    $error("button_array_ctrl: DEB_DEPTH must be 2..8");
  end

  logic [N_BTN-1:0] ch_out;
  logic [N_BTN-1:0] pend_q, pend_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEB_DEPTH  (DEB_DEPTH),
      .TMR_W      (TMR_W),
      .INT_TICKS  (INT_TICKS),
      .LONG_TICKS (LONG_TICKS),
      .STROBE_MODE(RST_MASK[i])
    ) u_ch (
      .SlowClock    (SlowClock),
      .MainReset    (MainReset),
      .strobe16_i   (Strobe16ms),
      .strobe125_i  (Strobe125ms),
      .btn_n_i      (ButtonIn[i]),
      .btn_out_o    (ch_out[i]),
      .press_irq_o  (PressIrq[i]),
      .release_irq_o(ReleaseIrq[i]),
      .long_press_o (LongPress[i])
`ifdef BTN_STUCK_DETECT_EN
      ,
      .stuck_o      (Stuck[i])
`endif
    );
  end

  // New IRQ pulses win over an ack landing in the same cycle.
  assign pend_d = (pend_q & ~IrqAck) | PressIrq | ReleaseIrq;

  // Sticky interrupt status.
  always_ff @(posedge SlowClock or negedge MainReset) begin
    if (!MainReset) pend_q <= '0;
    else            pend_q <= pend_d;
  end

  assign IrqPending = pend_q;
  assign ButtonOut  = ch_out | Inhibit;

endmodule

// File: tb/tb_button_array_ctrl.sv
// Scoreboard bench for button_array_ctrl. Strobes are time-compressed
// (16 ms = 8 cycles, 125 ms = 64 cycles) so multi-second holds stay short;
// every 8th Strobe16ms coincides with Strobe125ms.
module tb_button_array_ctrl;
  localparam int N = 2, T16 = 8, T125 = 64, DEB = 3, INT_T = 7, LONG_T = 31;
  localparam logic [N-1:0] MASK = 2'b10;

  typedef enum int {EV_OUT, EV_PRESS, EV_REL, EV_LONG, EV_PEND} ev_e;
  typedef struct { ev_e k; int ch; logic v; int c; } ev_t;

  logic SlowClock = 1'b0, MainReset = 1'b0, Strobe16ms = 1'b0, Strobe125ms = 1'b0;
  logic [N-1:0] ButtonIn = '1, Inhibit = '0, IrqAck = '0;
  logic [N-1:0] ButtonOut, PressIrq, ReleaseIrq, LongPress, IrqPending;
`ifdef BTN_STUCK_DETECT_EN
  logic [N-1:0] Stuck;
`endif

  int  cyc = 0, nchk = 0, nerr = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];

  button_array_ctrl dut (
    .SlowClock  (SlowClock),
    .MainReset  (MainReset),
    .Strobe16ms (Strobe16ms),
    .Strobe125ms(Strobe125ms),
    .ButtonIn   (ButtonIn),
    .Inhibit    (Inhibit),
    .IrqAck     (IrqAck),
    .ButtonOut  (ButtonOut),
    .PressIrq   (PressIrq),
    .ReleaseIrq (ReleaseIrq),
    .LongPress  (LongPress),
    .IrqPending (IrqPending)
`ifdef BTN_STUCK_DETECT_EN
    ,
    .Stuck      (Stuck)
`endif
  );

  always #5 SlowClock = ~SlowClock;

  task automatic chk(input string tag, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int nm(input int x, input int m);
    return ((x + m - 1) / m) * m;
  endfunction

  task automatic ev(input ev_e k, input int ch, input logic v, input int c);
    ev_t e;
    e.k = k; e.ch = ch; e.v = v; e.c = c;
    exp_q.push_back(e);
  endtask

  // Cycle cyc is sampled by the posedge that follows this negedge.
  task automatic tick();
    @(negedge SlowClock);
    cyc++;
    Strobe16ms  = (cyc % T16 == 0);
    Strobe125ms = (cyc % T125 == 0);
  endtask

  task automatic see(input ev_e k, input int ch, input logic v);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].k == k && exp_q[i].ch == ch && exp_q[i].v === v) begin
        idx = i;
        break;
      end
    if (idx < 0) chk($sformatf("spurious %s%0d->%0d", k.name(), ch, v), cyc, -1);
    else begin
      chk($sformatf("%s%0d->%0d", k.name(), ch, v), cyc, exp_q[idx].c);
      exp_q.delete(idx);
    end
  endtask

  // Every output edge must match a queued expectation at the predicted cycle.
  initial begin : mon
    logic [N-1:0] po, pp, pr, pl, pi;
    wait (mon_en);
    po = ButtonOut; pp = PressIrq; pr = ReleaseIrq; pl = LongPress; pi = IrqPending;
    forever begin
      @(posedge SlowClock);
      #1;
      for (int c = 0; c < N; c++) begin
        if (ButtonOut[c]  !== po[c]) see(EV_OUT,   c, ButtonOut[c]);
        if (PressIrq[c]   !== pp[c]) see(EV_PRESS, c, PressIrq[c]);
        if (ReleaseIrq[c] !== pr[c]) see(EV_REL,   c, ReleaseIrq[c]);
        if (LongPress[c]  !== pl[c]) see(EV_LONG,  c, LongPress[c]);
        if (IrqPending[c] !== pi[c]) see(EV_PEND,  c, IrqPending[c]);
      end
      po = ButtonOut; pp = PressIrq; pr = ReleaseIrq; pl = LongPress; pi = IrqPending;
    end
  end

  // Press channel ch now, hold win 125 ms windows past Status clearing, release.
  task automatic hold_press(input int ch, input int win, input bit ack_same);
    int p, s3, t1, r, h3, pc, lc, cc, fin;
    bit fires, longs, inh, lvl;
    p = cyc; ButtonIn[ch] = 1'b0;
    s3 = nm(p, T16) + (DEB - 1) * T16;
    t1 = nm(s3 + 1, T125);
    r  = s3 + win * T125;
    h3 = nm(r, T16) + (DEB - 1) * T16;
    pc = t1 + INT_T * T125;
    lc = t1 + (LONG_T - 1) * T125 + 1;
    cc = nm(h3 + 1, T125) + 1;
    fires = (pc - T125 <= h3);
    longs = (lc - 1 <= h3);
    inh = Inhibit[ch];
    lvl = !MASK[ch];
    if (lvl && !inh) begin ev(EV_OUT, ch, 0, s3); ev(EV_OUT, ch, 1, h3); end
    if (fires) begin
      ev(EV_PRESS, ch, 1, pc); ev(EV_PRESS, ch, 0, pc + 1);
      ev(EV_PEND, ch, 1, pc + 1); ev(EV_PEND, ch, 0, pc + 8);
    end
    if (longs) begin
      ev(EV_LONG, ch, 1, lc); ev(EV_LONG, ch, 0, cc);
      if (!lvl && !inh) begin ev(EV_OUT, ch, 0, lc); ev(EV_OUT, ch, 1, lc + T125); end
    end
    ev(EV_REL, ch, 1, h3); ev(EV_REL, ch, 0, h3 + 1);
    ev(EV_PEND, ch, 1, h3 + 1); ev(EV_PEND, ch, 0, h3 + 16);
    fin = h3 + 3 * T125;
    while (cyc < fin) begin
      tick();
      ButtonIn[ch] = (cyc >= r);
      IrqAck[ch] = (fires && cyc == pc + 8) || (ack_same && cyc == h3 + 1) || (cyc == h3 + 16);
      if (longs && cyc == lc + T125 / 2) begin
        chk("long_mid", LongPress[ch], 1);
        chk("out_mid", ButtonOut[ch], inh ? 1 : 0);
      end
    end
    chk("out_idle", ButtonOut[ch], 1);
    chk("pend_idle", IrqPending[ch], 0);
  endtask

  initial begin : stim
    int p, s3, t1, pc;
    repeat (5) tick();
    chk("rst_out",  ButtonOut, 3);
    chk("rst_press", PressIrq, 0);
    chk("rst_rel",  ReleaseIrq, 0);
    chk("rst_long", LongPress, 0);
    chk("rst_pend", IrqPending, 0);
    MainReset = 1'b1;
    mon_en = 1'b1;

    // Idle for 1 s: nothing moves.
    repeat (8 * T125) tick();
    chk("idle_out", ButtonOut, 3);
    chk("idle_pend", IrqPending, 0);

    // Level channel held 2 s, strobe channel held 5 s.
    hold_press(0, 16, 1'b0);
    hold_press(1, 40, 1'b0);

    // Two-sample glitch on channel 0 must not change Status.
    while (cyc % T16 != 1) tick();
    ButtonIn[0] = 1'b0;
    repeat (2 * T16) tick();
    ButtonIn[0] = 1'b1;
    repeat (T125) tick();
    chk("glitch_out", ButtonOut[0], 1);
    chk("glitch_pend", IrqPending[0], 0);

    // Short press with IrqAck coinciding with ReleaseIrq: set wins.
    hold_press(0, 4, 1'b1);

    // Inhibited long press: ButtonOut[1] stays high, LongPress still asserts.
    Inhibit[1] = 1'b1;
    hold_press(1, 40, 1'b0);
    Inhibit[1] = 1'b0;

    // Reset mid-hold at timer = 20, button kept low through reset.
    p = cyc; ButtonIn[1] = 1'b0;
    s3 = nm(p, T16) + (DEB - 1) * T16;
    t1 = nm(s3 + 1, T125);
    pc = t1 + INT_T * T125;
    ev(EV_PRESS, 1, 1, pc); ev(EV_PRESS, 1, 0, pc + 1); ev(EV_PEND, 1, 1, pc + 1);
    while (cyc < t1 + 19 * T125 + 10) tick();
    MainReset = 1'b0;
    ev(EV_PEND, 1, 0, cyc);
    tick();
    chk("mrst_out",  ButtonOut, 3);
    chk("mrst_long", LongPress, 0);
    chk("mrst_pend", IrqPending, 0);
    chk("mrst_press", PressIrq, 0);
    tick();
    MainReset = 1'b1;
    hold_press(1, 40, 1'b0);

    repeat (2 * T125) tick();
    chk("missing", exp_q.size(), 0);
    foreach (exp_q[i])
      $display("  unseen %s ch%0d ->%0d at cyc %0d", exp_q[i].k.name(), exp_q[i].ch, exp_q[i].v, exp_q[i].c);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: cyc %0d exceeded budget", cyc);
    $fatal(1, "timeout");
  end

endmodule
